data_memory_sized: RTL and testbench

Parametrised, byte-addressable data memory for the RISC-V core's MEM stage. It replaces the flat word-indexed array with RV32I load/store sizing (LB/LH/LW/LBU/LHU, SB/SH/SW) and byte-lane writes. It uses a req/ready/rvalid handshake with a configurable number of wait states, and flags illegal or misaligned accesses. The core's MEM stage stalls on `ready`/`rvalid`.

---
 rtl/data_memory_sized.sv | 232 +++++++++++++++++++++++
 tb/tb_data_memory_sized.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/data_memory_sized.sv
// Byte-addressable RV32I data memory with LB/LH/LW/LBU/LHU/SB/SH/SW sizing,
// a req/ready/rvalid handshake with WAIT_STATES wait cycles, and error reporting.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module data_memory_sized #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] read_data,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam bit         NO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         we_q, we_d;
  logic [2:0]   f3_q, f3_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  wdata_q, wdata_d;
  logic [31:0]  read_data_q, read_data_d;
  logic         err_q, err_d;

  logic [31:0]  mem_q [DEPTH_WORDS];

  logic              a_we_s;
  logic [2:0]        a_f3_s;
  logic [31:0]       a_addr_s;
  logic [31:0]       a_wdata_s;
  logic [IDX_W-1:0]  a_idx_s;
  logic [1:0]        a_off_s;
  logic              bad_s;
  logic              commit_s;
  logic [31:0]       word_s;
  logic [31:0]       shifted_s;
  logic [31:0]       load_val_s;
  logic              wr_en_s;
  logic [3:0]        wr_be_s;
  logic [31:0]       wr_word_s;
  logic              unused_s;

  function automatic logic is_illegal(input logic w, input logic [2:0] f3);
    logic r;
    if (w) begin
      r = !((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010));
    end else begin
      r = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
    return r;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic r;
`ifdef DMEM_MISALIGN_TRAP_EN
    r = ((f3[1:0] == 2'b01) && lo[0]) || ((f3 == 3'b010) && (lo != 2'b00));
`else
    r = 1'b0 & (^{f3, lo});
`endif
    return r;
  endfunction

  // Access fields: live inputs while accepting in IDLE, latched copy afterwards.
  always_comb begin
    if (state_q == ST_IDLE) begin
      a_we_s    = we;
      a_f3_s    = funct3;
      a_addr_s  = address;
      a_wdata_s = write_data;
    end else begin
      a_we_s    = we_q;
      a_f3_s    = f3_q;
      a_addr_s  = addr_q;
      a_wdata_s = wdata_q;
    end
  end

  assign a_idx_s  = a_addr_s[IDX_W+1:2];
  assign unused_s = ^{addr_q, address};

  // Lane offset (aligned for half/word) plus load extraction and store lane steering.
  always_comb begin
    a_off_s    = a_addr_s[1:0];
    load_val_s = 32'h0000_0000;
    wr_be_s    = 4'b0000;
    wr_word_s  = 32'h0000_0000;
    bad_s      = is_illegal(a_we_s, a_f3_s) | is_misaligned(a_f3_s, a_addr_s[1:0]);
    case (a_f3_s[1:0])
      2'b01:   a_off_s = {a_addr_s[1], 1'b0};
      2'b10:   a_off_s = 2'b00;
      default: a_off_s = a_addr_s[1:0];
    endcase
    word_s    = mem_q[a_idx_s];
    shifted_s = word_s >> {a_off_s, 3'b000};
    case (a_f3_s[1:0])
      2'b00: begin
        load_val_s = a_f3_s[2] ? {24'h00_0000, shifted_s[7:0]}
                               : {{24{shifted_s[7]}}, shifted_s[7:0]};
        wr_be_s    = 4'b0001 << a_off_s;
        wr_word_s  = {4{a_wdata_s[7:0]}};
      end
      2'b01: begin
        load_val_s = a_f3_s[2] ? {16'h0000, shifted_s[15:0]}
                               : {{16{shifted_s[15]}}, shifted_s[15:0]};
        wr_be_s    = a_off_s[1] ? 4'b1100 : 4'b0011;
        wr_word_s  = {2{a_wdata_s[15:0]}};
      end
      2'b10: begin
        load_val_s = word_s;
        wr_be_s    = 4'b1111;
        wr_word_s  = a_wdata_s;
      end
      default: begin
        load_val_s = 32'h0000_0000;
        wr_be_s    = 4'b0000;
        wr_word_s  = 32'h0000_0000;
      end
    endcase
  end

  // Next-state, counter, request latch and response capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    err_d       = err_q;
    commit_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = we;
          f3_d    = funct3;
          addr_d  = address;
          wdata_d = write_data;
          if (NO_WAIT) begin
            state_d  = ST_RESP;
            commit_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d  = ST_RESP;
          commit_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (commit_s) begin
      err_d       = bad_s;
      read_data_d = (bad_s || a_we_s) ? 32'h0000_0000 : load_val_s;
    end else begin
      err_d       = err_q;
      read_data_d = read_data_q;
    end
  end

  // Gated by rst_n so a request seen during reset can never write.
  assign wr_en_s = commit_s && a_we_s && !bad_s && rst_n;

  // Control and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      read_data_q <= 32'h0000_0000;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      err_q       <= err_d;
    end
  end

  // Storage array: byte-lane writes, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_s[b]) begin
          mem_q[a_idx_s][8*b +: 8] <= wr_word_s[8*b +: 8];
        end
      end
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign rvalid    = (state_q == ST_RESP);
  assign read_data = read_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench for data_memory_sized (WAIT_STATES = 2): the driver queues
// expected responses, a monitor pops and checks them whenever rvalid is seen.
module tb_data_memory_sized;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        ready;
  logic        rvalid;
  logic [31:0] read_data;
  logic        err;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        chk_rd;
    int          issue;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] last_rd;
  bit          have_last = 1'b0;

  data_memory_sized #(.DEPTH_WORDS(1024), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .funct3(funct3),
    .address(address), .write_data(write_data), .ready(ready),
    .rvalid(rvalid), .read_data(read_data), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  // Monitor: compare every response with the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      have_last = 1'b0;
    end else if (rvalid) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_rvalid");
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_err"}, {31'd0, err}, {31'd0, e.err});
        if (e.chk_rd) check({e.name, "_rdata"}, read_data, e.rd);
        check({e.name, "_latency"}, 32'(cyc - e.issue), 32'(WS + 1));
        last_rd   = read_data;
        have_last = 1'b1;
      end
    end else if (have_last) begin
      check("rdata_hold", read_data, last_rd);
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ready) fail_now("ready_timeout");
  endtask

  task automatic access(input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] erd, input logic eerr,
                        input logic chk, input string nm);
    exp_t e;
    int   t = 0;
    wait_ready();
    we = w; funct3 = f; address = a; write_data = d; req = 1'b1;
    e.rd = erd; e.err = eerr; e.chk_rd = chk; e.issue = cyc; e.name = nm;
    exp_q.push_back(e);
    @(negedge clk);
    req = 1'b0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      fail_now({nm, "_response_timeout"});
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'b000;
    address = 32'h0; write_data = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_rvalid", {31'd0, rvalid}, 32'd0);
    check("reset_rdata", read_data, 32'h0);
    check("reset_err", {31'd0, err}, 32'd0);

    access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, "sw_10");
    access(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, "lw_10");
    access(1'b1, 3'b000, 32'h11, 32'h0000007F, 32'h0, 1'b0, 1'b0, "sb_11");
    access(1'b0, 3'b000, 32'h11, 32'h0, 32'h0000007F, 1'b0, 1'b1, "lb_11");
    access(1'b1, 3'b000, 32'h12, 32'hFFFFFF80, 32'h0, 1'b0, 1'b0, "sb_12");
    access(1'b0, 3'b000, 32'h12, 32'h0, 32'hFFFFFF80, 1'b0, 1'b1, "lb_12");
    access(1'b0, 3'b100, 32'h12, 32'h0, 32'h00000080, 1'b0, 1'b1, "lbu_12");
    access(1'b0, 3'b010, 32'h10, 32'h0, 32'hDE807FEF, 1'b0, 1'b1, "lw_10_merged");
    access(1'b1, 3'b001, 32'h1002, 32'h00008001, 32'h0, 1'b0, 1'b0, "sh_1002");
    access(1'b0, 3'b001, 32'h2, 32'h0, 32'hFFFF8001, 1'b0, 1'b1, "lh_2_alias");
    access(1'b0, 3'b101, 32'h2, 32'h0, 32'h00008001, 1'b0, 1'b1, "lhu_2_alias");
`ifdef DMEM_MISALIGN_TRAP_EN
    access(1'b0, 3'b001, 32'h13, 32'h0, 32'h0, 1'b1, 1'b1, "lh_13_misalign");
`else
    access(1'b0, 3'b001, 32'h13, 32'h0, 32'hFFFFDE80, 1'b0, 1'b1, "lh_13_forced");
`endif
    access(1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1, 1'b1, "load_illegal_110");
    access(1'b1, 3'b011, 32'h10, 32'h12345678, 32'h0, 1'b1, 1'b1, "store_illegal_011");
    access(1'b0, 3'b010, 32'h10, 32'h0, 32'hDE807FEF, 1'b0, 1'b1, "lw_after_illegal");

    // Reset during WAIT of a store: no response expected, word keeps old value.
    wait_ready();
    we = 1'b1; funct3 = 3'b010; address = 32'h10; write_data = 32'hCAFEF00D; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset_ready", {31'd0, ready}, 32'd1);
    check("midreset_rvalid", {31'd0, rvalid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_no_resp", {31'd0, rvalid}, 32'd0);
    access(1'b0, 3'b010, 32'h10, 32'h0, 32'hDE807FEF, 1'b0, 1'b1, "lw_after_midreset");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
